// File: rtl/gpio_pad_if.sv
// gpio_pad_if: controller/pad-ring bundle between the GPIO register block and gpio_pad_ctrl
interface gpio_pad_if #(
  parameter int GPIO_NUM = 32,
  parameter int DB_WIDTH = 8
);
  logic [GPIO_NUM-1:0] gpio_out_i;
  logic [GPIO_NUM-1:0] gpio_dir_i;
  logic [GPIO_NUM-1:0] gpio_iof_i;
  logic [GPIO_NUM-1:0] iof_out_i;
  logic [GPIO_NUM-1:0] iof_dir_i;
  logic [DB_WIDTH-1:0] db_cnt_i;
  logic [GPIO_NUM-1:0] pad_in_i;
  logic [GPIO_NUM-1:0] pad_out_o;
  logic [GPIO_NUM-1:0] pad_oe_o;
  logic [GPIO_NUM-1:0] gpio_in_o;
  logic [GPIO_NUM-1:0] iof_in_o;
  modport master (
    output gpio_out_i, gpio_dir_i, gpio_iof_i, iof_out_i, iof_dir_i, db_cnt_i, pad_in_i,
    input  pad_out_o, pad_oe_o, gpio_in_o, iof_in_o
  );
  modport slave (
    input  gpio_out_i, gpio_dir_i, gpio_iof_i, iof_out_i, iof_dir_i, db_cnt_i, pad_in_i,
    output pad_out_o, pad_oe_o, gpio_in_o, iof_in_o
  );
endinterface

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: registered pad output mux with alternate function, plus synchronised and debounced pad inputs
module gpio_pad_ctrl #(
  parameter int GPIO_NUM = 32,
  parameter int DB_WIDTH = 8
) (
  input logic clk_i,
  input logic rst_i,
  gpio_pad_if.slave bus
);
  logic [GPIO_NUM-1:0] s1, s2, st, pad_out, pad_oe;
  logic [DB_WIDTH-1:0] cnt [GPIO_NUM];
  logic [DB_WIDTH:0] thr;
  // one extra bit keeps cnt+1 from wrapping at the maximum threshold
  assign thr = (bus.db_cnt_i == '0) ? (DB_WIDTH+1)'(1) : {1'b0, bus.db_cnt_i};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1 <= '0;
      s2 <= '0;
      st <= '0;
      pad_out <= '0;
      pad_oe <= '0;
      for (int i = 0; i < GPIO_NUM; i++) cnt[i] <= '0;
    end else begin
      s1 <= bus.pad_in_i;
      s2 <= s1;
      pad_out <= (bus.gpio_iof_i & bus.iof_out_i) | (~bus.gpio_iof_i & bus.gpio_out_i);
      pad_oe <= (bus.gpio_iof_i & bus.iof_dir_i) | (~bus.gpio_iof_i & bus.gpio_dir_i);
      for (int i = 0; i < GPIO_NUM; i++) begin
        if (s2[i] == st[i]) cnt[i] <= '0;
        else if ({1'b0, cnt[i]} + (DB_WIDTH+1)'(1) >= thr) begin
          st[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  assign bus.pad_out_o = pad_out;
  assign bus.pad_oe_o = pad_oe;
  assign bus.gpio_in_o = st;
  assign bus.iof_in_o = st;
endmodule
